// File: rtl/fma16_unpack.sv
// fma16_unpack: unpacks and classifies three binary16 operands, normalizing subnormals serially
module fma16_unpack #(
  parameter int NE = 5,
  parameter int NF = 10,
  parameter int EW = NE + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NE+NF:0]   x,
  input  logic [NE+NF:0]   y,
  input  logic [NE+NF:0]   z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             xs,
  output logic             ys,
  output logic             zs,
  output logic [EW-1:0]    xe,
  output logic [EW-1:0]    ye,
  output logic [EW-1:0]    ze,
  output logic [NF:0]      xm,
  output logic [NF:0]      ym,
  output logic [NF:0]      zm,
  output logic [3:0]       xcls,
  output logic [3:0]       ycls,
  output logic [3:0]       zcls,
  output logic             invalid
);
  localparam int W = NE + NF + 1;
  typedef enum logic [2:0] {IDLE, NX, NY, NZ, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] xr, yr, zr, op;
  logic [NE-1:0] ef;
  logic [NF-1:0] ff;
  logic [EW-1:0] we, e_n;
  logic [NF:0] wm, m_n;
  logic [3:0] cls_n;
  logic run, done;
  function automatic logic snan(input logic [W-1:0] v);
    return (&v[W-2:NF]) && (v[NF-1:0] != '0) && !v[NF-1];
  endfunction
  // decode the operand owned by the current state; a running subnormal keeps shifting
  always_comb begin
    op = state == NX ? xr : state == NY ? yr : zr;
    ef = op[W-2:NF];
    ff = op[NF-1:0];
    cls_n = (&ef) ? (ff == '0 ? 4'b0100 : 4'b1000) : ef == '0 ? (ff == '0 ? 4'b0001 : 4'b0010) : 4'b0000;
    m_n = run ? wm << 1 : cls_n[1] ? {1'b0, ff} << 1 : cls_n[0] ? '0 : {1'b1, ff};
    e_n = run ? we - EW'(1) : (cls_n[1] | cls_n[0]) ? '0 : EW'(ef);
    done = m_n[NF] | (!run & cls_n[0]);
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: each operand state advances only when its decode completes
  always_comb
    state_n = state == IDLE ? (in_valid ? NX : IDLE) :
              state == DONE ? (out_ready ? IDLE : DONE) :
              !done ? state : state == NX ? NY : state == NY ? NZ : DONE;
  // handshake outputs
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // operand capture, subnormal working registers and registered results
  always_ff @(posedge clk)
    if (reset) begin
      {xr, yr, zr} <= '0;
      {we, wm, run} <= '0;
      {xs, ys, zs, xe, ye, ze, xm, ym, zm, xcls, ycls, zcls, invalid} <= '0;
    end else begin
      if (state == IDLE && in_valid) {xr, yr, zr} <= {x, y, z};
      run <= (state == NX || state == NY || state == NZ) && !done;
      if (!done) begin
        we <= e_n;
        wm <= m_n;
      end
      if (done && state == NX) {xs, xe, xm, xcls} <= {op[W-1], e_n, m_n, cls_n};
      if (done && state == NY) {ys, ye, ym, ycls} <= {op[W-1], e_n, m_n, cls_n};
      if (done && state == NZ) {zs, ze, zm, zcls} <= {op[W-1], e_n, m_n, cls_n};
      if (done && state == NZ) invalid <= snan(xr) | snan(yr) | snan(zr);
      if (state == DONE && out_ready) invalid <= 1'b0;
    end
endmodule

// File: tb/tb_fma16_unpack.sv
// tb_fma16_unpack: directed vectors with hand-computed expectations for fma16_unpack
module tb_fma16_unpack;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [15:0] x = 0, y = 0, z = 0;
  logic in_ready, out_valid, xs, ys, zs, invalid;
  logic [6:0] xe, ye, ze;
  logic [10:0] xm, ym, zm;
  logic [3:0] xcls, ycls, zcls;
  int checks = 0, errors = 0, lat;
  logic [63:0] snap;

  fma16_unpack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .xs(xs), .ys(ys), .zs(zs), .xe(xe), .ye(ye), .ze(ze),
    .xm(xm), .ym(ym), .zm(zm), .xcls(xcls), .ycls(ycls), .zcls(zcls),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    x = a; y = b; z = c; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out();
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
  endtask

  function automatic logic [63:0] pins();
    return {xs, ys, zs, xe, ye, ze, xm, ym, zm, xcls, ycls, zcls, invalid};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_pins", pins(), 0);
    reset = 0;
    send(16'h3C00, 16'hC000, 16'h0000);
    chk("busy_in_ready", in_ready, 0);
    wait_out();
    chk("s1_lat", lat, 3);
    chk("s1_x", {xs, xe, xm, xcls}, {1'b0, 7'h0F, 11'h400, 4'b0000});
    chk("s1_y", {ys, ye, ym, ycls}, {1'b1, 7'h10, 11'h400, 4'b0000});
    chk("s1_z", {zs, ze, zm, zcls}, {1'b0, 7'h00, 11'h000, 4'b0001});
    chk("s1_invalid", invalid, 0);
    snap = pins();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_pins", pins(), snap);
    end
    handshake();
    send(16'h0001, 16'h0200, 16'h3C00);
    chk("b2b_accepted", in_ready, 0);
    wait_out();
    chk("s2_lat", lat, 12);
    chk("s2_x", {xs, xe, xm, xcls}, {1'b0, 7'h77, 11'h400, 4'b0010});
    chk("s2_y", {ys, ye, ym, ycls}, {1'b0, 7'h00, 11'h400, 4'b0010});
    chk("s2_z", {zs, ze, zm, zcls}, {1'b0, 7'h0F, 11'h400, 4'b0000});
    chk("s2_invalid", invalid, 0);
    handshake();
    send(16'hFC00, 16'h7E00, 16'h7C01);
    wait_out();
    chk("s3_lat", lat, 3);
    chk("s3_x", {xs, xe, xm, xcls}, {1'b1, 7'h1F, 11'h400, 4'b0100});
    chk("s3_y", {ys, ye, ym, ycls}, {1'b0, 7'h1F, 11'h600, 4'b1000});
    chk("s3_z", {zs, ze, zm, zcls}, {1'b0, 7'h1F, 11'h401, 4'b1000});
    chk("s3_invalid", invalid, 1);
    handshake();
    chk("s3_invalid_clr", invalid, 0);
    send(16'h0001, 16'h0000, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_out_valid", out_valid, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_pins", pins(), 0);
    send(16'h4200, 16'h3800, 16'h8400);
    wait_out();
    chk("s4_lat", lat, 3);
    chk("s4_x", {xs, xe, xm, xcls}, {1'b0, 7'h10, 11'h600, 4'b0000});
    chk("s4_y", {ys, ye, ym, ycls}, {1'b0, 7'h0E, 11'h400, 4'b0000});
    chk("s4_z", {zs, ze, zm, zcls}, {1'b1, 7'h01, 11'h400, 4'b0000});
    handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fma16_unpack.md
Name: fma16_unpack

Overview:
Sequential operand unpacker and decoder at the front of the fma16 datapath. It is the counterpart to the result packer/rounder. It accepts three packed binary16 operands x, y, z on a valid/ready handshake and classifies each one. Subnormals are normalized one bit per cycle. It presents sign, extended signed exponent, explicit-leading-one mantissa and class flags to the multiply/add stages on a second valid/ready handshake.

Parameters:
NE, 5, exponent field width of the packed format
NF, 10, fraction field width of the packed format
EW, NE+2, width of the unpacked signed (two's complement) biased exponent

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands x/y/z valid
in_ready  output  1  block can accept operands
x, y, z  input  NE+NF+1 each  packed operands
out_valid  output  1  unpacked operands valid
out_ready  input  1  downstream accepts unpacked operands
xs, ys, zs  output  1 each  operand signs
xe, ye, ze  output  EW each  signed biased exponents
xm, ym, zm  output  NF+1 each  mantissas, bit NF is the explicit leading one
xcls, ycls, zcls  output  4 each  one-hot-or-zero class, bits {nan, inf, sub, zero}; 0 means normal
invalid  output  1  any operand is a signaling NaN (NaN with frac bit NF-1 = 0)

Behaviour:
- Only clk is used; reset is synchronous and active-high. Reset takes priority over every other input, including mid-operation.
- Reset values: state IDLE, in_ready=1, out_valid=0, invalid=0; all s/e/m/cls outputs are 0.
- FSM states: IDLE, NX, NY, NZ, DONE. In_ready=1 only in IDLE.
- IDLE: on in_valid & in_ready, capture x/y/z into internal registers and go to NX. Otherwise stay in IDLE.
- Per-operand decode in state Nn, all outputs registered:
  - exp field all 1s, frac=0: inf. e=2^NE-1, m={1,frac}.
  - exp field all 1s, frac!=0: nan. e=2^NE-1, m={1,frac}.
  - exp=0, frac=0: zero. e=0, m=0.
  - exp in 1..2^NE-2: normal. e=zero-extended exp, m={1,frac}.
  - exp=0, frac!=0: sub. Working e starts at 1 and m at {0,frac}. Each cycle do m<<=1 and e-=1. Leave the state on the cycle whose shifted m has bit NF set.
- Cycles per state: non-subnormal operands take 1 cycle. A subnormal takes k cycles, with k = NF - (index of frac's leading one), so k is in 1..NF. Final e = 1-k, which can be negative (down to -9 at default parameters).
- Transitions: NX→NY→NZ→DONE after each operand completes.
- Latency: out_valid rises 3 + Σ(k_i-1) clock edges after the acceptance edge, where the sum runs over subnormal operands only.
- DONE: out_valid=1. Outputs and invalid hold stable while out_valid & ~out_ready.
- On out_valid & out_ready: out_valid=0 next edge, state → IDLE, and in_ready=1 on that same edge. No new operands are accepted during the DONE cycle, so throughput is at most one operand set per (latency+1) cycles.
- Outputs of the previous set remain on the pins after the handshake until they are overwritten during the next operand processing. Consumers must sample only when out_valid=1.
- invalid is the OR of sNaN detection over all three operands. It is updated at DONE entry and cleared when state returns to IDLE.
- in_valid deasserting while not in IDLE is ignored.
- reset asserted in any state: next edge returns to IDLE with reset values; the in-flight set is discarded.

Test Plan:
- x=0x3C00, y=0xC000, z=0x0000 accepted at edge E0 → out_valid at E3. xs=0 xe=0x0F xm=0x400 xcls=0; ys=1 ye=0x10 ym=0x400; zcls=0001 ze=0 zm=0; invalid=0.
- x=0x0001, y=0x0200, z=0x3C00 → out_valid at E0+12. xe=7'h77 (-9) xm=0x400 xcls=0010; ye=0 ym=0x400 ycls=0010.
- x=0xFC00, y=0x7E00, z=0x7C01 → xcls=0100 xs=1 xe=0x1F; ycls=1000; zcls=1000 zm=0x401; invalid=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → outputs and in_ready=0 held constant. out_ready=1 → out_valid=0 and in_ready=1 on the next edge. Back-to-back in_valid is accepted on the following cycle.
- reset asserted during NX processing x=0x0001 (cycle 4 of 10) → next edge: state IDLE, in_ready=1, out_valid=0, all outputs 0. A subsequent normal set completes with latency 3.
